// File: rtl/rv_pkg.sv
// Shared RV32I core types: register-file geometry, pending counters and the writeback payload.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = $clog2(NUM_REGS);
  localparam int unsigned PEND_W   = 2;

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [PEND_W-1:0] pend_cnt_t;

  // Writeback request as seen by the register file.
  typedef struct packed {
    logic      we;
    reg_addr_t rd;
    xlen_t     data;
  } wb_req_t;

  function automatic logic is_x0(input reg_addr_t a);
    return a == '0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-writer counters plus the decode-facing pending/full flags.
// REG_FILE_BYPASS_EN lets a same-cycle writeback retire the last outstanding writer early.
module rf_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned PEND_W   = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_issue,
  input  logic                        i_issue_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_issue_rd,
  input  logic                        i_reg_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_reg,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs2,
  output logic                        o_rs1_pending,
  output logic                        o_rs2_pending,
  output logic                        o_issue_full
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];

  // Counter update: simultaneous issue and writeback cancel; saturate at both ends.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      if (r != 0) begin
        if (i_issue && i_issue_we && i_issue_rd == AW'(r) &&
            !(i_reg_we && i_reg == AW'(r))) begin
          if (pend_q[r] != '1) pend_d[r] = pend_q[r] + PEND_W'(1);
        end else if (i_reg_we && i_reg == AW'(r) &&
                     !(i_issue && i_issue_we && i_issue_rd == AW'(r))) begin
          if (pend_q[r] != '0) pend_d[r] = pend_q[r] - PEND_W'(1);
        end
      end
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    o_rs1_pending = (pend_q[i_rs1] != '0) && (i_rs1 != '0);
    o_rs2_pending = (pend_q[i_rs2] != '0) && (i_rs2 != '0);
`ifdef REG_FILE_BYPASS_EN
    if (i_reg_we && i_reg == i_rs1 && pend_q[i_rs1] == PEND_W'(1)) o_rs1_pending = 1'b0;
    if (i_reg_we && i_reg == i_rs2 && pend_q[i_rs2] == PEND_W'(1)) o_rs2_pending = 1'b0;
`endif
    o_issue_full  = i_issue_we && (pend_q[i_issue_rd] == '1);
  end

  // A writeback must always retire a previously issued writer.
  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_reg_we && i_reg != '0) |-> (pend_q[i_reg] != '0))
    else $error("rf_scoreboard: writeback to x%0d with no pending writer", i_reg);

endmodule

// File: rtl/reg_file.sv
// RV32I architectural register file: 32x32 flops, x0 hardwired to zero, two async read ports.
// Define REG_FILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module reg_file #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned PEND_W   = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_reg_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_reg,
  input  logic [31:0]                 i_reg_data,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs2,
  output logic [31:0]                 o_rs1_data,
  output logic [31:0]                 o_rs2_data,
  input  logic                        i_issue,
  input  logic                        i_issue_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_issue_rd,
  output logic                        o_rs1_pending,
  output logic                        o_rs2_pending,
  output logic                        o_issue_full
);

  import rv_pkg::*;

  localparam int unsigned AW = $clog2(NUM_REGS);

  wb_req_t      wb_c;
  logic [31:0]  mem_q [NUM_REGS];
  logic [31:0]  mem_d [NUM_REGS];

  always_comb begin
    wb_c      = '0;
    wb_c.we   = i_reg_we;
    wb_c.rd   = REG_AW'(i_reg);
    wb_c.data = i_reg_data;
  end

  // Write port; x0 is never written so it stays at its reset value of zero.
  always_comb begin
    mem_d = mem_q;
    if (wb_c.we && !is_x0(wb_c.rd)) mem_d[AW'(wb_c.rd)] = wb_c.data;
    mem_d[0] = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    o_rs1_data = (i_rs1 == '0) ? '0 : mem_q[i_rs1];
    o_rs2_data = (i_rs2 == '0) ? '0 : mem_q[i_rs2];
`ifdef REG_FILE_BYPASS_EN
    if (wb_c.we && AW'(wb_c.rd) == i_rs1 && i_rs1 != '0) o_rs1_data = wb_c.data;
    if (wb_c.we && AW'(wb_c.rd) == i_rs2 && i_rs2 != '0) o_rs2_data = wb_c.data;
`endif
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PEND_W   (PEND_W)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue       (i_issue),
    .i_issue_we    (i_issue_we),
    .i_issue_rd    (i_issue_rd),
    .i_reg_we      (i_reg_we),
    .i_reg         (i_reg),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .o_rs1_pending (o_rs1_pending),
    .o_rs2_pending (o_rs2_pending),
    .o_issue_full  (o_issue_full)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we;
  logic [4:0]  reg_a;
  logic [31:0] reg_data;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic        issue, issue_we;
  logic [4:0]  issue_rd;
  logic        rs1_pend, rs2_pend, issue_full;

  int n_cmp = 0;
  int n_err = 0;

  reg_file dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_reg_we      (reg_we),
    .i_reg         (reg_a),
    .i_reg_data    (reg_data),
    .i_rs1         (rs1),
    .i_rs2         (rs2),
    .o_rs1_data    (rs1_data),
    .o_rs2_data    (rs2_data),
    .i_issue       (issue),
    .i_issue_we    (issue_we),
    .i_issue_rd    (issue_rd),
    .o_rs1_pending (rs1_pend),
    .o_rs2_pending (rs2_pend),
    .o_issue_full  (issue_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; reg_we = 1'b0; reg_a = '0; reg_data = '0;
    rs1 = '0; rs2 = '0; issue = 1'b0; issue_we = 1'b0; issue_rd = '0;
  endtask

  task automatic issue_one(input logic [4:0] rd);
    idle(); issue = 1'b1; issue_we = 1'b1; issue_rd = rd;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    idle();
    for (int r = 1; r < 32; r++) begin
      rs1 = 5'(r); rs2 = 5'(32 - r);
      #1;
      n_cmp++;
      if (rs1_data !== 32'h0) begin n_err++; $display("FAIL reset_rs1_data x%0d: got %h want 00000000", r, rs1_data); end
      n_cmp++;
      if (rs2_data !== 32'h0) begin n_err++; $display("FAIL reset_rs2_data x%0d: got %h want 00000000", 32 - r, rs2_data); end
      n_cmp++;
      if (rs1_pend !== 1'b0 || rs2_pend !== 1'b0) begin
        n_err++; $display("FAIL reset_pending x%0d: got %b%b want 00", r, rs1_pend, rs2_pend);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    issue_one(5'd5);
    rs1 = 5'd5; #1;
    n_cmp++;
    if (rs1_pend !== 1'b1) begin n_err++; $display("FAIL x5_pending_after_issue: got %b want 1", rs1_pend); end
    reg_we = 1'b1; reg_a = 5'd5; reg_data = 32'hDEADBEEF; #1;
    n_cmp++;
    if (rs1_data !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
      n_err++; $display("FAIL x5_same_cycle_data: got %h want %h", rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
    end
    n_cmp++;
    if (rs1_pend !== !BYP) begin n_err++; $display("FAIL x5_same_cycle_pending: got %b want %b", rs1_pend, !BYP); end
    tick();
    idle(); rs1 = 5'd5; rs2 = 5'd5; #1;
    n_cmp++;
    if (rs1_data !== 32'hDEADBEEF || rs2_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL x5_next_cycle_data: got %h/%h want deadbeef", rs1_data, rs2_data);
    end
    n_cmp++;
    if (rs1_pend !== 1'b0) begin n_err++; $display("FAIL x5_next_cycle_pending: got %b want 0", rs1_pend); end
    idle();
  endtask

  task automatic test_x0();
    idle(); reg_we = 1'b1; reg_a = 5'd0; reg_data = 32'hFFFFFFFF;
    rs1 = 5'd0; rs2 = 5'd0; issue_we = 1'b1; issue_rd = 5'd0; #1;
    n_cmp++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      n_err++; $display("FAIL x0_same_cycle: got %h/%h want 0", rs1_data, rs2_data);
    end
    n_cmp++;
    if (issue_full !== 1'b0) begin n_err++; $display("FAIL x0_issue_full: got %b want 0", issue_full); end
    issue = 1'b1;
    tick();
    idle(); rs1 = 5'd0; rs2 = 5'd0; #1;
    n_cmp++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      n_err++; $display("FAIL x0_after_write: got %h/%h want 0", rs1_data, rs2_data);
    end
    n_cmp++;
    if (rs1_pend !== 1'b0 || rs2_pend !== 1'b0) begin
      n_err++; $display("FAIL x0_pending: got %b%b want 00", rs1_pend, rs2_pend);
    end
    idle();
  endtask

  task automatic test_saturate();
    issue_one(5'd7);
    issue_one(5'd7);
    issue_we = 1'b1; issue_rd = 5'd7; #1;
    n_cmp++;
    if (issue_full !== 1'b0) begin n_err++; $display("FAIL x7_full_at_2: got %b want 0", issue_full); end
    issue_one(5'd7);
    rs1 = 5'd7; rs2 = 5'd7; issue_we = 1'b1; issue_rd = 5'd7; #1;
    n_cmp++;
    if (rs1_pend !== 1'b1 || rs2_pend !== 1'b1) begin
      n_err++; $display("FAIL x7_pending_at_3: got %b%b want 11", rs1_pend, rs2_pend);
    end
    n_cmp++;
    if (issue_full !== 1'b1) begin n_err++; $display("FAIL x7_full_at_3: got %b want 1", issue_full); end
    // A fourth issue must not wrap the counter back to zero.
    issue_one(5'd7);
    for (int k = 1; k <= 3; k++) begin
      idle(); reg_we = 1'b1; reg_a = 5'd7; reg_data = 32'(k) * 32'h1111_0000; rs1 = 5'd7; #1;
      n_cmp++;
      if (rs1_pend !== ((k == 3) ? !BYP : 1'b1)) begin
        n_err++; $display("FAIL x7_wb%0d_same_cycle_pending: got %b want %b", k, rs1_pend, (k == 3) ? !BYP : 1'b1);
      end
      tick();
      idle(); rs1 = 5'd7; rs2 = 5'd7; #1;
      n_cmp++;
      if (rs1_pend !== (k != 3)) begin
        n_err++; $display("FAIL x7_wb%0d_next_pending: got %b want %b", k, rs1_pend, k != 3);
      end
      n_cmp++;
      if (rs2_data !== 32'(k) * 32'h1111_0000) begin
        n_err++; $display("FAIL x7_wb%0d_data: got %h want %h", k, rs2_data, 32'(k) * 32'h1111_0000);
      end
    end
    idle();
  endtask

  task automatic test_issue_and_wb();
    issue_one(5'd9);
    issue = 1'b1; issue_we = 1'b1; issue_rd = 5'd9;
    reg_we = 1'b1; reg_a = 5'd9; reg_data = 32'h0000_0099; rs1 = 5'd9; #1;
    n_cmp++;
    if (rs1_pend !== !BYP) begin n_err++; $display("FAIL x9_same_cycle_pending: got %b want %b", rs1_pend, !BYP); end
    tick();
    idle(); rs1 = 5'd9; #1;
    n_cmp++;
    if (rs1_pend !== 1'b1) begin n_err++; $display("FAIL x9_pending_held: got %b want 1", rs1_pend); end
    n_cmp++;
    if (rs1_data !== 32'h0000_0099) begin n_err++; $display("FAIL x9_data: got %h want 00000099", rs1_data); end
    reg_we = 1'b1; reg_a = 5'd9; reg_data = 32'h0000_0999;
    tick();
    idle(); rs1 = 5'd9; #1;
    n_cmp++;
    if (rs1_pend !== 1'b0 || rs1_data !== 32'h0000_0999) begin
      n_err++; $display("FAIL x9_retired: got pend=%b data=%h want pend=0 data=00000999", rs1_pend, rs1_data);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    issue_one(5'd10);
    issue_one(5'd11);
    reg_we = 1'b1; reg_a = 5'd10; reg_data = 32'hAAAA_0010;
    issue = 1'b1; issue_we = 1'b1; issue_rd = 5'd12;
    tick();
    idle(); reg_we = 1'b1; reg_a = 5'd11; reg_data = 32'hBBBB_0011;
    rs1 = 5'd10; rs2 = 5'd11; #1;
    n_cmp++;
    if (rs1_data !== 32'hAAAA_0010 || rs1_pend !== 1'b0) begin
      n_err++; $display("FAIL b2b_x10: got data=%h pend=%b want aaaa0010/0", rs1_data, rs1_pend);
    end
    n_cmp++;
    if (rs2_data !== (BYP ? 32'hBBBB_0011 : 32'h0) || rs2_pend !== !BYP) begin
      n_err++; $display("FAIL b2b_x11_same_cycle: got data=%h pend=%b want %h/%b",
                        rs2_data, rs2_pend, BYP ? 32'hBBBB_0011 : 32'h0, !BYP);
    end
    tick();
    idle(); rs1 = 5'd12; rs2 = 5'd11; #1;
    n_cmp++;
    if (rs1_pend !== 1'b1 || rs2_pend !== 1'b0 || rs2_data !== 32'hBBBB_0011) begin
      n_err++; $display("FAIL b2b_after: got p12=%b p11=%b d11=%h want 1/0/bbbb0011", rs1_pend, rs2_pend, rs2_data);
    end
    reg_we = 1'b1; reg_a = 5'd12; reg_data = 32'h0000_0012;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    issue_one(5'd3);
    issue_one(5'd3);
    issue_one(5'd3);
    reg_we = 1'b1; reg_a = 5'd3; reg_data = 32'h0000_0033;
    tick();
    idle(); rs1 = 5'd3; #1;
    n_cmp++;
    if (rs1_data !== 32'h0000_0033 || rs1_pend !== 1'b1) begin
      n_err++; $display("FAIL x3_before_reset: got data=%h pend=%b want 00000033/1", rs1_data, rs1_pend);
    end
    rst = 1'b1; reg_we = 1'b1; reg_a = 5'd3; reg_data = 32'h0000_0044;
    issue = 1'b1; issue_we = 1'b1; issue_rd = 5'd3;
    tick();
    idle(); rs1 = 5'd3; rs2 = 5'd5; issue_we = 1'b1; issue_rd = 5'd3; #1;
    n_cmp++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_data: got %h/%h want 0", rs1_data, rs2_data);
    end
    n_cmp++;
    if (rs1_pend !== 1'b0 || issue_full !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_flags: got pend=%b full=%b want 0/0", rs1_pend, issue_full);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_x0();
    test_saturate();
    test_issue_and_wb();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
